// File: rtl/mdu_ctrl_if.sv
// E-stage request and HI/LO result bundle for the multiply/divide sequencer.
// The E stage drives the master side and mdu_ctrl implements the slave side.
interface mdu_ctrl_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        md_use;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, op, a, b, flush, md_use,
                   input  busy, stall, hi, lo);
   modport slave  (input  start, op, a, b, flush, md_use,
                   output busy, stall, hi, lo);
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: computes the result up front, holds it in pending
// registers while a busy counter models latency, then commits to HI/LO.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic       clk,
   input logic       reset,
   mdu_ctrl_if.slave md
);
   localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CntW      = $clog2(MaxCycles + 1);
   localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES);
   localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          r_state, w_nextState;
   logic [CntW-1:0] r_count, w_nextCount;
   logic [31:0]     r_pHi, r_pLo, r_hi, r_lo;
   logic [31:0]     w_nextPHi, w_nextPLo, w_nextHi, w_nextLo;
   logic            w_accept, w_busy, w_divZero;
   logic [63:0]     w_sProd, w_uProd;
   logic [31:0]     w_uQuot, w_uRem, w_absA, w_absB, w_mQuot, w_mRem, w_sQuot, w_sRem;

   assign w_busy   = (r_state == BUSY);
   assign w_accept = md.start & ~md.flush & ~w_busy;

   assign w_sProd   = $signed({{32{md.a[31]}}, md.a}) * $signed({{32{md.b[31]}}, md.b});
   assign w_uProd   = {32'b0, md.a} * {32'b0, md.b};
   assign w_divZero = (md.b == 32'b0);
   assign w_uQuot   = w_divZero ? 32'b0 : md.a / md.b;
   assign w_uRem    = w_divZero ? 32'b0 : md.a % md.b;

   // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
   assign w_absA  = md.a[31] ? -md.a : md.a;
   assign w_absB  = md.b[31] ? -md.b : md.b;
   assign w_mQuot = w_divZero ? 32'b0 : w_absA / w_absB;
   assign w_mRem  = w_divZero ? 32'b0 : w_absA % w_absB;
   assign w_sQuot = (md.a[31] ^ md.b[31]) ? -w_mQuot : w_mQuot;
   assign w_sRem  = md.a[31] ? -w_mRem : w_mRem;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_count <= '0;
         r_pHi   <= '0;
         r_pLo   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_state <= w_nextState;
         r_count <= w_nextCount;
         r_pHi   <= w_nextPHi;
         r_pLo   <= w_nextPLo;
         r_hi    <= w_nextHi;
         r_lo    <= w_nextLo;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_nextCount = r_count;
      w_nextPHi   = r_pHi;
      w_nextPLo   = r_pLo;
      w_nextHi    = r_hi;
      w_nextLo    = r_lo;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               case (md.op)
                  3'd0: begin
                     {w_nextPHi, w_nextPLo} = w_sProd;
                     w_nextCount = MultLoad;
                     w_nextState = BUSY;
                  end
                  3'd1: begin
                     {w_nextPHi, w_nextPLo} = w_uProd;
                     w_nextCount = MultLoad;
                     w_nextState = BUSY;
                  end
                  // A zero divisor re-commits the current HI/LO, leaving them unchanged.
                  3'd2: begin
                     w_nextPHi   = w_divZero ? r_hi : w_sRem;
                     w_nextPLo   = w_divZero ? r_lo : w_sQuot;
                     w_nextCount = DivLoad;
                     w_nextState = BUSY;
                  end
                  3'd3: begin
                     w_nextPHi   = w_divZero ? r_hi : w_uRem;
                     w_nextPLo   = w_divZero ? r_lo : w_uQuot;
                     w_nextCount = DivLoad;
                     w_nextState = BUSY;
                  end
                  3'd4: w_nextHi = md.a;
                  3'd5: w_nextLo = md.a;
                  default: ;
               endcase
            end
         end
         BUSY: begin
            w_nextCount = r_count - CntW'(1);
            if (r_count == CntW'(1)) begin
               w_nextHi    = r_pHi;
               w_nextLo    = r_pLo;
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   assign md.busy  = w_busy;
   assign md.stall = md.md_use & (w_busy | (md.start & ~md.flush & ~md.op[2]));
   assign md.hi    = r_hi;
   assign md.lo    = r_lo;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vector table, hand-written corner
// sequences, then random operations checked against a plain-arithmetic model.
module tb_mdu_ctrl;
   localparam int MultN = 5;
   localparam int DivN  = 10;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mdu_ctrl_if bus ();

   mdu_ctrl #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expHi;
      logic [31:0] expLo;
      int          cycles;
   } vec_t;

   vec_t vecs[5];

   task automatic applyStimulus(input logic start, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic flush, input logic mdUse);
      bus.start  = start;
      bus.op     = op;
      bus.a      = a;
      bus.b      = b;
      bus.flush  = flush;
      bus.md_use = mdUse;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Reference: 64-bit arithmetic straight from the ISA definitions.
   function automatic void modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   inout logic [31:0] h, inout logic [31:0] l, output int cyc);
      longint          sa, sb, q, r, p;
      longint unsigned up;
      cyc = 0;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      case (op)
         3'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; cyc = MultN; end
         3'd1: begin up = longint'(a) * longint'(b); h = up[63:32]; l = up[31:0]; cyc = MultN; end
         3'd2: begin
            cyc = DivN;
            if (b != 0) begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
         end
         3'd3: begin
            cyc = DivN;
            if (b != 0) begin h = a % b; l = a / b; end
         end
         3'd4: h = a;
         3'd5: l = a;
         default: ;
      endcase
   endfunction

   task automatic doReset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Issues one op in the current cycle, then measures busy length and checks HI/LO hold and commit.
   task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic flush, input logic [31:0] expHi, input logic [31:0] expLo, input int expCycles);
      logic [31:0] hi0, lo0;
      logic        changed;
      int          n;
      hi0     = bus.hi;
      lo0     = bus.lo;
      changed = 1'b0;
      applyStimulus(1'b1, op, a, b, flush, 1'b0);
      @(posedge clk); #1;
      applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput({name, " accept"}, 64'(bus.busy), 64'(expCycles > 0));
      n = 0;
      while (bus.busy && n < 100) begin
         if (bus.hi !== hi0 || bus.lo !== lo0) changed = 1'b1;
         n++;
         @(posedge clk); #1;
      end
      checkOutput({name, " cycles"}, 64'(n), 64'(expCycles));
      if (expCycles > 0) checkOutput({name, " hold"}, 64'(changed), 64'(0));
      checkOutput({name, " hi"}, 64'(bus.hi), 64'(expHi));
      checkOutput({name, " lo"}, 64'(bus.lo), 64'(expLo));
   endtask

   initial begin
      logic [31:0] mHi, mLo, ra, rb;
      logic [2:0]  rop;
      logic        rflush, bad;
      int          cyc, n;

      checks = 0;
      errors = 0;
      clk    = 1'b0;
      reset  = 1'b1;
      applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      checkOutput("reset busy", 64'(bus.busy), 64'(0));
      checkOutput("reset stall", 64'(bus.stall), 64'(0));
      checkOutput("reset hi", 64'(bus.hi), 64'(0));
      checkOutput("reset lo", 64'(bus.lo), 64'(0));

      vecs[0] = '{"mult", 3'd0, 32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA, MultN};
      vecs[1] = '{"multu", 3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, MultN};
      vecs[2] = '{"divu b2b", 3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, DivN};
      vecs[3] = '{"div neg", 3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DivN};
      vecs[4] = '{"div ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DivN};
      for (int i = 0; i < 5; i++)
         runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].expHi, vecs[i].expLo, vecs[i].cycles);

      runOp("div zero", 3'd2, 32'h00001234, 32'h0, 1'b0, 32'h00000000, 32'h80000000, DivN);
      runOp("divu zero", 3'd3, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h00000000, 32'h80000000, DivN);
      runOp("reserved op", 3'd6, 32'h11111111, 32'h2, 1'b0, 32'h00000000, 32'h80000000, 0);

      // mthi then mtlo on consecutive cycles.
      applyStimulus(1'b1, 3'd4, 32'h12345678, 32'h0, 1'b0, 1'b0);
      @(posedge clk); #1;
      checkOutput("mthi hi", 64'(bus.hi), 64'h12345678);
      checkOutput("mthi busy", 64'(bus.busy), 64'(0));
      applyStimulus(1'b1, 3'd5, 32'h9ABCDEF0, 32'h0, 1'b0, 1'b0);
      @(posedge clk); #1;
      applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("mtlo lo", 64'(bus.lo), 64'h9ABCDEF0);
      checkOutput("mtlo hi kept", 64'(bus.hi), 64'h12345678);
      checkOutput("mtlo busy", 64'(bus.busy), 64'(0));

      // Flushed start: no stall, no state change.
      applyStimulus(1'b1, 3'd0, 32'h5, 32'h5, 1'b1, 1'b1);
      #1;
      checkOutput("flush stall", 64'(bus.stall), 64'(0));
      @(posedge clk); #1;
      applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("flush busy", 64'(bus.busy), 64'(0));
      checkOutput("flush lo", 64'(bus.lo), 64'h9ABCDEF0);

      // Stall in the start cycle and throughout BUSY; flush during BUSY must not cancel.
      applyStimulus(1'b1, 3'd2, 32'd20, 32'd6, 1'b0, 1'b1);
      #1;
      checkOutput("stall start", 64'(bus.stall), 64'(1));
      @(posedge clk); #1;
      applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b1);
      bad = 1'b0;
      n   = 0;
      while (bus.busy && n < 100) begin
         if (bus.stall !== 1'b1) bad = 1'b1;
         n++;
         @(posedge clk); #1;
      end
      checkOutput("stall busy", 64'(bad), 64'(0));
      checkOutput("stall cycles", 64'(n), 64'(DivN));
      checkOutput("stall done", 64'(bus.stall), 64'(0));
      checkOutput("flushbusy hi", 64'(bus.hi), 64'd2);
      checkOutput("flushbusy lo", 64'(bus.lo), 64'd3);
      applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Reset in the third busy cycle of a divide aborts it.
      applyStimulus(1'b1, 3'd3, 32'd100, 32'd7, 1'b0, 1'b0);
      @(posedge clk); #1;
      applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("abort busy", 64'(bus.busy), 64'(0));
      checkOutput("abort hi", 64'(bus.hi), 64'(0));
      checkOutput("abort lo", 64'(bus.lo), 64'(0));
      repeat (12) begin @(posedge clk); #1; end
      checkOutput("abort nocommit", {bus.hi, bus.lo}, 64'(0));

      // Random operations against the reference model.
      doReset();
      mHi = 32'h0;
      mLo = 32'h0;
      for (int i = 0; i < 60; i++) begin
         rop    = 3'($urandom_range(0, 7));
         ra     = $urandom;
         rb     = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
         rflush = ($urandom_range(0, 7) == 0);
         cyc    = 0;
         if (!rflush) modelOp(rop, ra, rb, mHi, mLo, cyc);
         runOp($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, rflush, mHi, mLo, cyc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit sequencer for the five-stage pipeline. It accepts a multiply, divide or HI/LO-move operation from the E stage and models the multi-cycle latency with a busy counter. It commits results to architectural HI/LO registers and drives the stall request that holds D/E while a dependent instruction waits. Results reach the W stage through the existing MD pipeline path via the `hi`/`lo` outputs.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- Clock is `clk`. Reset is `reset`: synchronous, active-high.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  E-stage MD operation valid this cycle
- op  in  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6-7 reserved (ignored)
- a  in  32  rs operand
- b  in  32  rt operand
- flush  in  1  exception/interrupt flush from CP0; suppresses start in the same cycle
- md_use  in  1  D-stage instruction is an MD op or mfhi/mflo
- busy  out  1  operation in progress
- stall  out  1  stall request to hazard unit
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- States: IDLE and BUSY. A down-counter is sized for max(MULT_CYCLES, DIV_CYCLES).
- Accepted start means `start & ~flush & ~busy`. Accepted starts with op 6-7 have no effect.
- IDLE, accepted mult/multu/div/divu:
  - Compute the result in the same cycle into pending regs `p_hi`/`p_lo`.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY.
- IDLE, accepted mthi/mtlo:
  - Write `a` into HI or LO at that clock edge.
  - Stay in IDLE; no busy.
- BUSY:
  - Decrement the counter each cycle.
  - When the counter is 1: copy `p_hi`/`p_lo` to HI/LO, go to IDLE, clear busy.
- start while BUSY is ignored; the hazard unit guarantees this never happens.
- flush never cancels an operation already in BUSY; it completes and commits.
- Arithmetic:
  - mult: signed 64-bit product; {HI,LO}=a*b.
  - multu: unsigned 64-bit product.
  - div: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - div of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (div or divu): counter still runs full DIV_CYCLES, HI/LO keep their previous values, no exception.
- stall = md_use & (busy | (start & ~flush & op<=3)).
- busy = (state == BUSY).

## Timing
- Reset: state IDLE, counter 0, busy=0, stall=0 (when md_use=0), hi=0, lo=0, p_hi=p_lo=0.
- Reset mid-operation aborts it; HI/LO become 0 at that edge and no later commit occurs.
- Start accepted at edge t:
  - busy=1 from t+1 through t+N, where N = cycle count.
  - HI/LO updated at edge t+N, visible in cycle t+N+1.
  - busy=0 in cycle t+N+1.
- A new start in cycle t+N+1 is accepted (back-to-back with no gap cycle beyond busy).
- mthi/mtlo: HI/LO visible in the cycle after start.
- stall is combinational. During the start cycle it is high when md_use=1 and the E-stage op is mult/multu/div/divu, so that mfhi/mflo in D cannot read stale HI/LO.
- hi/lo are registered outputs; they never change while BUSY except at the commit edge.

## Test plan
- Reset, then mult a=3, b=0xFFFFFFFE (MULT_CYCLES=5) -> busy high for 5 cycles; next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE; back-to-back divu a=7, b=2 started the cycle busy drops -> accepted; after 10 cycles lo=3, hi=1.
- div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. div by zero -> busy for 10 cycles, HI/LO unchanged.
- mthi a=0x12345678, then mtlo a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated one cycle each, busy never asserted.
- start=1 with flush=1 -> no state change, busy=0. flush asserted during BUSY -> operation still commits. md_use=1 during BUSY -> stall=1 each cycle until busy=0.
- reset asserted at the 3rd busy cycle of a div -> next cycle busy=0, hi=lo=0, and no commit at the original completion time.
